// File: rtl/switch_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_sched_pkg
// Description : Shared types, constants and helpers for the switch output
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_sched_pkg;

    // Width of one head-of-queue metadata word
    localparam int META_W = 32;

    // Per-output scheduler state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } sched_state_t;

    // Extract the destination-port field from a metadata word.
    // The result is zero-extended so it can be compared against any port index.
    function automatic logic [META_W-1:0] dest_field(
        input logic [META_W-1:0] word,
        input int                lsb,
        input int                width
    );
        logic [META_W-1:0] mask;
        mask = (META_W'(1) << width) - META_W'(1);
        return (word >> lsb) & mask;
    endfunction

endpackage : switch_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotating-priority picker. Returns the first
//               requester strictly after ptr, wrapping N-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] w_idx;

    // Scan from farthest to nearest offset so the nearest requester after ptr wins
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        w_idx     = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = IDX_W'((int'(ptr) + k) % N);
            if (req[w_idx]) begin
                grant_any = 1'b1;
                grant_idx = w_idx;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/switch_output_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : switch_output_scheduler
// Description : Per-output round-robin packet scheduler. Picks an input per
//               output, runs the start/ready handshake with the output port
//               controller and drives the crossbar select.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_output_scheduler
    import switch_sched_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int NUM_OUT  = 4,
    parameter int DEST_LSB = 0,
    parameter int DEST_W   = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [NUM_IN-1:0]                  meta_valid,
    input  logic [NUM_IN*META_W-1:0]           meta_data,
    input  logic [NUM_OUT-1:0]                 ready_transfer,
    output logic [NUM_OUT-1:0]                 start_transfer,
    output logic [NUM_OUT*$clog2(NUM_IN)-1:0]  sel,
    output logic [NUM_OUT-1:0]                 sel_valid,
    output logic [NUM_OUT-1:0]                 start_err
);

    localparam int SEL_W = $clog2(NUM_IN);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // An input stays locked from grant until its transfer is released or
    // timed out, so a stale head-of-queue word is never granted twice.
    logic [NUM_IN-1:0]                r_lock;
    logic [NUM_OUT-1:0][NUM_IN-1:0]   w_req;
    logic [NUM_OUT-1:0][NUM_IN-1:0]   w_lock_set;
    logic [NUM_OUT-1:0][NUM_IN-1:0]   w_lock_clr;
    logic [NUM_IN-1:0]                w_set_all;
    logic [NUM_IN-1:0]                w_clr_all;

    // Request matrix: valid, unlocked input whose destination is this output
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                w_req[o][i] = meta_valid[i] && !r_lock[i] &&
                    (dest_field(meta_data[META_W*i +: META_W], DEST_LSB, DEST_W) == META_W'(o));
            end
        end
    end

    // Merge lock set/clear requests from all outputs
    always_comb begin
        w_set_all = '0;
        w_clr_all = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            w_set_all = w_set_all | w_lock_set[o];
            w_clr_all = w_clr_all | w_lock_clr[o];
        end
    end

    // Shared input lock mask
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lock <= '0;
        end else begin
            r_lock <= (r_lock & ~w_clr_all) | w_set_all;
        end
    end

    generate
        for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
            sched_state_t      r_state, w_state_nxt;
            logic              r_start, w_start_nxt;
            logic              r_selv,  w_selv_nxt;
            logic              r_err,   w_err_nxt;
            logic [SEL_W-1:0]  r_sel,   w_sel_nxt;
            logic [SEL_W-1:0]  r_ptr,   w_ptr_nxt;
            logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
            logic [CNT_W-1:0]  w_cnt_inc;
            logic [SEL_W-1:0]  w_gidx;
            logic              w_gany;
            logic [NUM_IN-1:0] w_set;
            logic [NUM_IN-1:0] w_clr;

            rr_arbiter #(
                .N     (NUM_IN),
                .IDX_W (SEL_W)
            ) u_arb (
                .req       (w_req[o]),
                .ptr       (r_ptr),
                .grant_idx (w_gidx),
                .grant_any (w_gany)
            );

            assign w_cnt_inc      = r_cnt + CNT_W'(1);
            assign w_lock_set[o]  = w_set;
            assign w_lock_clr[o]  = w_clr;

            // Next-state and output decode for this output's handshake FSM
            always_comb begin
                w_state_nxt = r_state;
                w_start_nxt = r_start;
                w_selv_nxt  = r_selv;
                w_err_nxt   = 1'b0;
                w_sel_nxt   = r_sel;
                w_ptr_nxt   = r_ptr;
                w_cnt_nxt   = r_cnt;
                w_set       = '0;
                w_clr       = '0;
                case (r_state)
                    IDLE: begin
                        if (ready_transfer[o] && w_gany) begin
                            w_sel_nxt     = w_gidx;
                            w_selv_nxt    = 1'b1;
                            w_start_nxt   = 1'b1;
                            w_ptr_nxt     = w_gidx;
                            w_cnt_nxt     = '0;
                            w_set[w_gidx] = 1'b1;
                            w_state_nxt   = START;
                        end
                    end
                    START: begin
                        if (!ready_transfer[o]) begin
                            w_start_nxt = 1'b0;
                            w_state_nxt = BUSY;
                        end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                            // Controller never acknowledged: abandon, keep rr_ptr on g
                            w_start_nxt  = 1'b0;
                            w_selv_nxt   = 1'b0;
                            w_err_nxt    = 1'b1;
                            w_clr[r_sel] = 1'b1;
                            w_state_nxt  = IDLE;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                    BUSY: begin
                        if (ready_transfer[o]) begin
                            w_state_nxt = RELEASE;
                        end
                    end
                    RELEASE: begin
                        w_selv_nxt   = 1'b0;
                        w_clr[r_sel] = 1'b1;
                        w_state_nxt  = IDLE;
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end

            // State and output registers for this output
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_state <= IDLE;
                    r_start <= 1'b0;
                    r_selv  <= 1'b0;
                    r_err   <= 1'b0;
                    r_sel   <= '0;
                    r_ptr   <= SEL_W'(NUM_IN - 1);
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_start <= w_start_nxt;
                    r_selv  <= w_selv_nxt;
                    r_err   <= w_err_nxt;
                    r_sel   <= w_sel_nxt;
                    r_ptr   <= w_ptr_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            assign start_transfer[o]           = r_start;
            assign sel_valid[o]                = r_selv;
            assign start_err[o]                = r_err;
            assign sel[o*SEL_W +: SEL_W]       = r_sel;
        end
    endgenerate

endmodule : switch_output_scheduler
`default_nettype wire
